// File: rtl/signed_divider_16x8_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_pkg
//  Description : Shared types and constants for the 16/8 signed divider.
//  Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

    // Operand / iteration widths, fixed to pair with the 8x8 multiplier
    localparam int DIVIDEND_W = 16;
    localparam int DIVISOR_W  = 8;
    localparam int ITER       = 16;

    // Quotient saturation limits
    localparam logic [DIVISOR_W-1:0] Q_MAX = 8'h7F;
    localparam logic [DIVISOR_W-1:0] Q_MIN = 8'h80;

    // Controller states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } div_state_t;

    // Magnitude of a 16-bit two's complement value; -32768 maps to 0x8000
    function automatic logic [DIVIDEND_W-1:0] mag16(input logic [DIVIDEND_W-1:0] v);
        return v[DIVIDEND_W-1] ? (~v + 16'd1) : v;
    endfunction

    // Magnitude of an 8-bit two's complement value; -128 maps to 0x80
    function automatic logic [DIVISOR_W-1:0] mag8(input logic [DIVISOR_W-1:0] v);
        return v[DIVISOR_W-1] ? (~v + 8'd1) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/signed_divider_16x8_if.sv
`default_nettype none
// ============================================================================
//  Module      : signed_divider_16x8_if
//  Description : Request/result bundle for the 16/8 signed divider.
//  Revision    : 1.0 - initial release
// ============================================================================
interface signed_divider_16x8_if;
    import div_pkg::*;

    logic                   start;
    logic [DIVIDEND_W-1:0]  dividend;
    logic [DIVISOR_W-1:0]   divisor;
    logic                   busy;
    logic                   done;
    logic [DIVISOR_W-1:0]   quotient;
    logic [DIVISOR_W-1:0]   remainder;
    logic                   ovf;
    logic                   dbz;

    // Requester side
    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, ovf, dbz
    );

    // Divider side
    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, ovf, dbz
    );

endinterface
`default_nettype wire

// File: rtl/signed_divider_16x8.sv
`default_nettype none
// ============================================================================
//  Module      : signed_divider_16x8
//  Description : Sequential signed divider, 16-bit dividend by 8-bit divisor.
//                Sign-magnitude restoring division, 16 iterations, fixed
//                17-cycle latency from accept to done. Quotient truncates
//                toward zero and saturates on overflow; remainder follows
//                the dividend sign.
//  Revision    : 1.0 - initial release
// ============================================================================
module signed_divider_16x8
    import div_pkg::*;
(
    input  wire logic            CLK,
    input  wire logic            RST,
    signed_divider_16x8_if.slave bus
);

    localparam logic [3:0] c_LAST_ITER = 4'(ITER - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    div_state_t             r_state;
    logic [3:0]             r_cnt;
    // Dividend magnitude shifts out MSB-first while quotient bits shift in
    logic [DIVIDEND_W-1:0]  r_dq;
    logic [DIVISOR_W-1:0]   r_dvs;
    logic [DIVISOR_W:0]     r_prem;
    logic                   r_neg_dvd;
    logic                   r_neg_dvs;
    logic                   r_dbz_pend;

    logic                   r_busy;
    logic                   r_done;
    logic [DIVISOR_W-1:0]   r_quot;
    logic [DIVISOR_W-1:0]   r_rem;
    logic                   r_ovf;
    logic                   r_dbz;

    // ------------------------------------------------------------------
    // Combinational step and result formatting
    // ------------------------------------------------------------------
    logic [DIVISOR_W+1:0]   w_shift;
    logic [DIVISOR_W:0]     w_diff;
    logic                   w_qbit;
    logic [DIVISOR_W:0]     w_prem_next;
    logic                   w_q_neg;
    logic                   w_ovf;
    logic [DIVISOR_W-1:0]   w_quot;
    logic [DIVISOR_W-1:0]   w_rem;

    // One restoring step: shift in next dividend bit, trial-subtract divisor
    always_comb begin
        w_shift     = {r_prem, r_dq[DIVIDEND_W-1]};
        w_qbit      = (w_shift >= {2'b00, r_dvs});
        // When the trial succeeds the true difference is below 256, so the
        // low 9 bits carry it exactly.
        w_diff      = w_shift[DIVISOR_W:0] - {1'b0, r_dvs};
        w_prem_next = w_qbit ? w_diff : w_shift[DIVISOR_W:0];
    end

    // Sign restoration and saturation of the finished magnitudes
    always_comb begin
        w_q_neg = r_neg_dvd ^ r_neg_dvs;
        w_ovf   = 1'b0;
        w_quot  = r_dq[DIVISOR_W-1:0];
        w_rem   = r_neg_dvd ? (8'd0 - r_prem[DIVISOR_W-1:0]) : r_prem[DIVISOR_W-1:0];
        if (w_q_neg) begin
            // Negative range reaches -128, so magnitude 128 is still exact
            w_ovf  = (r_dq > 16'd128);
            w_quot = w_ovf ? Q_MIN : (8'd0 - r_dq[DIVISOR_W-1:0]);
        end else begin
            w_ovf  = (r_dq > 16'd127);
            w_quot = w_ovf ? Q_MAX : r_dq[DIVISOR_W-1:0];
        end
        if (r_dbz_pend) begin
            w_ovf  = 1'b0;
            w_quot = '0;
            w_rem  = '0;
        end
    end

    // Controller and datapath: accept, iterate, register results
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_dq       <= '0;
            r_dvs      <= '0;
            r_prem     <= '0;
            r_neg_dvd  <= 1'b0;
            r_neg_dvs  <= 1'b0;
            r_dbz_pend <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_quot     <= '0;
            r_rem      <= '0;
            r_ovf      <= 1'b0;
            r_dbz      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_neg_dvd  <= bus.dividend[DIVIDEND_W-1];
                        r_neg_dvs  <= bus.divisor[DIVISOR_W-1];
                        r_dq       <= mag16(bus.dividend);
                        r_dvs      <= mag8(bus.divisor);
                        r_dbz_pend <= (bus.divisor == '0);
                        r_prem     <= '0;
                        r_cnt      <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= CALC;
                    end
                end
                CALC: begin
                    // Divide-by-zero still iterates so latency never varies
                    r_prem <= w_prem_next;
                    r_dq   <= {r_dq[DIVIDEND_W-2:0], w_qbit};
                    r_cnt  <= r_cnt + 4'd1;
                    if (r_cnt == c_LAST_ITER) begin
                        r_state <= FINISH;
                    end
                end
                FINISH: begin
                    r_quot  <= w_quot;
                    r_rem   <= w_rem;
                    r_ovf   <= w_ovf;
                    r_dbz   <= r_dbz_pend;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.quotient  = r_quot;
    assign bus.remainder = r_rem;
    assign bus.ovf       = r_ovf;
    assign bus.dbz       = r_dbz;

endmodule
`default_nettype wire
